wb_dcache_victim_ctrl: RTL and testbench

Parametrised next-generation write-back data-cache controller with an integrated victim-cache protocol. It sits between the LSU/MMU request port, the dcache datapath, an N-entry victim cache and the data-memory port. It adds line swaps on victim hits, victim write-back of displaced dirty entries, a flush sweep that drains the victim cache, and a memory-ack watchdog.

---
 rtl/wb_dcache_victim_ctrl_pkg.sv | 23 ++
 rtl/wb_dcache_victim_ctrl_dcache_mem_watchdog.sv | 43 ++++
 rtl/wb_dcache_victim_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_wb_dcache_victim_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_dcache_victim_ctrl_pkg.sv
// Shared definitions for the write-back dcache / victim-cache controller:
// default geometry constants and the controller state encoding.
package wb_dcache_victim_ctrl_pkg;

    localparam int DEF_IDX_BITS    = 11;
    localparam int DEF_VC_ENTRIES  = 4;
    localparam int DEF_MEM_TIMEOUT = 255;

    typedef enum logic [3:0] {
        IDLE,
        PROCESS,
        SWAP,
        VC_WB,
        DC_WB,
        ALLOCATE,
        FLUSH,
        FLUSH_NEXT,
        VFLUSH,
        VFLUSH_NEXT,
        FLUSH_DONE
    } type_dcache_vc_states_e;

endpackage

// File: rtl/wb_dcache_victim_ctrl_dcache_mem_watchdog.sv
// Memory-ack watchdog: counts consecutive waiting cycles and flags a timeout on
// the MEM_TIMEOUT-th such cycle; the counter clears whenever clr is asserted.
module dcache_mem_watchdog
    import wb_dcache_victim_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en && cnt_reg != LIMIT) begin
            cnt_next = cnt_reg + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Combinational on the registered count only, so the FSM can use it
    // without forming a loop through the clear term.
    assign timeout = en && (cnt_reg == LIMIT);

endmodule

// File: rtl/wb_dcache_victim_ctrl.sv
// Write-back dcache controller with victim-cache swap/insert/write-back, flush
// sweep and memory watchdog. Optional perf counters under WB_DCACHE_PERF_EN.
module wb_dcache_victim_ctrl
    import wb_dcache_victim_ctrl_pkg::*;
#(
    parameter  int IDX_BITS    = DEF_IDX_BITS,
    parameter  int VC_ENTRIES  = DEF_VC_ENTRIES,
    parameter  int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    localparam int VC_IDX_BITS = $clog2(VC_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lsu_req_i,
    input  logic                   lsu_wr_i,
    input  logic                   lsu_kill_i,
    input  logic                   dmem_sel_i,
    input  logic                   flush_i,
    output logic                   lsu_ack_o,
    output logic                   lsu_err_o,
    output logic                   lsu_vc_sel_o,
    input  logic                   cache_hit_i,
    input  logic                   cache_valid_i,
    input  logic                   cache_dirty_i,
    output logic                   cache_wr_o,
    output logic                   cache_line_wr_o,
    output logic                   cache_line_clean_o,
    output logic                   cache_wrb_req_o,
    output logic [IDX_BITS-1:0]    evict_index_o,
    input  logic                   vc_hit_i,
    input  logic                   vc_dirty_i,
    output logic                   vc_swap_o,
    output logic                   vc_insert_o,
    output logic                   vc_wrb_req_o,
    output logic                   vc_clean_o,
    output logic [VC_IDX_BITS-1:0] vc_index_o,
    input  logic                   mem_ack_i,
    output logic                   mem_req_o,
    output logic                   mem_wr_o,
    output logic                   mem_kill_o
`ifdef WB_DCACHE_PERF_EN
    ,
    output logic [31:0]            hit_cnt_o,
    output logic [31:0]            miss_cnt_o,
    output logic [31:0]            vc_hit_cnt_o,
    output logic [31:0]            wb_cnt_o
`endif
);

    localparam logic [IDX_BITS-1:0]    EVICT_ONE = IDX_BITS'(1);
    localparam logic [VC_IDX_BITS-1:0] VC_ONE    = VC_IDX_BITS'(1);
    localparam logic [VC_IDX_BITS-1:0] VC_LAST   = VC_IDX_BITS'(VC_ENTRIES - 1);

    type_dcache_vc_states_e state_reg, state_next;
    logic [IDX_BITS-1:0]    evict_index_reg, evict_index_next;
    logic [VC_IDX_BITS-1:0] vc_index_reg, vc_index_next;
    logic                   req_ff, wr_ff, sel_ff;

    logic hit, kill_req, mem_wait, wd_timeout, wd_clr, abort;
    logic evict_last, vc_last;

    assign hit        = req_ff && sel_ff && cache_hit_i;
    assign evict_last = (evict_index_reg == '1);
    assign vc_last    = (vc_index_reg == VC_LAST);

    // Only LSU transactions can be killed; the flush sweep runs to completion.
    assign kill_req = (state_reg inside {PROCESS, SWAP, VC_WB, ALLOCATE})
                      && (!dmem_sel_i || lsu_kill_i);

    // States that hold mem_req_o waiting for an acknowledge.
    assign mem_wait = (state_reg inside {VC_WB, ALLOCATE, DC_WB})
                      || (state_reg == VFLUSH && vc_dirty_i);

    assign abort  = mem_wait && wd_timeout && !mem_ack_i && !kill_req;
    assign wd_clr = (state_next != state_reg) || mem_ack_i;

    dcache_mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (mem_wait),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            evict_index_reg <= '0;
            vc_index_reg    <= '0;
            req_ff          <= 1'b0;
            wr_ff           <= 1'b0;
            sel_ff          <= 1'b0;
        end else begin
            state_reg       <= state_next;
            evict_index_reg <= evict_index_next;
            vc_index_reg    <= vc_index_next;
            req_ff          <= lsu_req_i;
            wr_ff           <= lsu_wr_i;
            sel_ff          <= dmem_sel_i;
        end
    end

    always_comb begin
        state_next       = state_reg;
        evict_index_next = evict_index_reg;
        vc_index_next    = vc_index_reg;
        if (kill_req) begin
            state_next       = IDLE;
            evict_index_next = '0;
            vc_index_next    = '0;
        end else if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    evict_index_next = '0;
                    vc_index_next    = '0;
                    if (flush_i) begin
                        state_next = FLUSH;
                    end else if (lsu_req_i) begin
                        state_next = PROCESS;
                    end
                end
                PROCESS: begin
                    if (hit) begin
                        state_next = IDLE;
                    end else if (vc_hit_i) begin
                        state_next = SWAP;
                    end else if (cache_valid_i && vc_dirty_i) begin
                        state_next = VC_WB;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
                SWAP:     state_next = IDLE;
                VC_WB:    if (mem_ack_i) state_next = ALLOCATE;
                ALLOCATE: if (mem_ack_i) state_next = PROCESS;
                FLUSH, DC_WB: begin
                    if ((state_reg == FLUSH && !cache_dirty_i) || (state_reg == DC_WB && mem_ack_i)) begin
                        if (evict_last) begin
                            state_next    = VFLUSH;
                            vc_index_next = '0;
                        end else begin
                            state_next       = FLUSH_NEXT;
                            evict_index_next = evict_index_reg + EVICT_ONE;
                        end
                    end else if (state_reg == FLUSH) begin
                        state_next = DC_WB;
                    end
                end
                FLUSH_NEXT: state_next = FLUSH;
                VFLUSH: begin
                    if (!vc_dirty_i || mem_ack_i) begin
                        if (vc_last) begin
                            state_next = FLUSH_DONE;
                        end else begin
                            state_next    = VFLUSH_NEXT;
                            vc_index_next = vc_index_reg + VC_ONE;
                        end
                    end
                end
                VFLUSH_NEXT: state_next = VFLUSH;
                FLUSH_DONE:  state_next = IDLE;
                default:     state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        lsu_ack_o          = 1'b0;
        lsu_err_o          = 1'b0;
        lsu_vc_sel_o       = 1'b0;
        cache_wr_o         = 1'b0;
        cache_line_wr_o    = 1'b0;
        cache_line_clean_o = 1'b0;
        cache_wrb_req_o    = 1'b0;
        vc_swap_o          = 1'b0;
        vc_insert_o        = 1'b0;
        vc_wrb_req_o       = 1'b0;
        vc_clean_o         = 1'b0;
        mem_req_o          = 1'b0;
        mem_wr_o           = 1'b0;
        mem_kill_o         = 1'b0;
        if (kill_req) begin
            mem_kill_o = 1'b1;
        end else if (abort) begin
            mem_kill_o = 1'b1;
            lsu_ack_o  = 1'b1;
            lsu_err_o  = 1'b1;
        end else begin
            unique case (state_reg)
                PROCESS: begin
                    if (hit) begin
                        lsu_ack_o  = 1'b1;
                        cache_wr_o = wr_ff;
                    end else if (vc_hit_i) begin
                        vc_swap_o    = 1'b1;
                        lsu_vc_sel_o = !wr_ff;
                    end else begin
                        vc_insert_o = cache_valid_i;
                        mem_req_o   = 1'b1;
                        if (cache_valid_i && vc_dirty_i) begin
                            mem_wr_o     = 1'b1;
                            vc_wrb_req_o = 1'b1;
                        end
                    end
                end
                SWAP: begin
                    cache_line_wr_o = 1'b1;
                    cache_wr_o      = wr_ff;
                    lsu_ack_o       = 1'b1;
                end
                VC_WB: begin
                    mem_req_o    = 1'b1;
                    mem_wr_o     = 1'b1;
                    vc_wrb_req_o = 1'b1;
                end
                ALLOCATE: begin
                    mem_req_o       = 1'b1;
                    cache_line_wr_o = mem_ack_i;
                end
                FLUSH: begin
                    mem_req_o       = cache_dirty_i;
                    mem_wr_o        = cache_dirty_i;
                    cache_wrb_req_o = cache_dirty_i;
                end
                DC_WB: begin
                    mem_req_o          = 1'b1;
                    mem_wr_o           = 1'b1;
                    cache_wrb_req_o    = 1'b1;
                    cache_line_clean_o = mem_ack_i;
                end
                VFLUSH: begin
                    mem_req_o    = vc_dirty_i;
                    mem_wr_o     = vc_dirty_i;
                    vc_wrb_req_o = vc_dirty_i;
                    vc_clean_o   = vc_dirty_i && mem_ack_i;
                end
                FLUSH_DONE: lsu_ack_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign evict_index_o = evict_index_reg;
    assign vc_index_o    = vc_index_reg;

`ifdef WB_DCACHE_PERF_EN
    logic [3:0]  perf_evt;
    logic [31:0] perf_cnt [4];

    assign perf_evt[0] = (state_reg == PROCESS) && !kill_req && hit;
    assign perf_evt[1] = (state_reg == PROCESS) && !kill_req && !hit && !vc_hit_i;
    assign perf_evt[2] = (state_reg == PROCESS) && !kill_req && !hit && vc_hit_i;
    assign perf_evt[3] = mem_wait && mem_ack_i && !kill_req && (state_reg != ALLOCATE);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (perf_evt[gi] && cnt_reg != '1) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
            assign perf_cnt[gi] = cnt_reg;
        end
    endgenerate

    assign hit_cnt_o    = perf_cnt[0];
    assign miss_cnt_o   = perf_cnt[1];
    assign vc_hit_cnt_o = perf_cnt[2];
    assign wb_cnt_o     = perf_cnt[3];
`endif

endmodule

// File: tb/tb_wb_dcache_victim_ctrl.sv
// Directed bench for wb_dcache_victim_ctrl (IDX_BITS=2, VC_ENTRIES=4, MEM_TIMEOUT=8):
// PROCESS-outcome vector table plus hand-written multi-cycle sequences.
module tb_wb_dcache_victim_ctrl;

    localparam int IDX_BITS    = 2;
    localparam int VC_ENTRIES  = 4;
    localparam int MEM_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lsu_req_i = 0, lsu_wr_i = 0, lsu_kill_i = 0, dmem_sel_i = 1, flush_i = 0;
    logic cache_hit_i = 0, cache_valid_i = 0, cache_dirty_i = 0;
    logic vc_hit_i = 0, vc_dirty_i = 0, mem_ack_i = 0;
    logic lsu_ack_o, lsu_err_o, lsu_vc_sel_o;
    logic cache_wr_o, cache_line_wr_o, cache_line_clean_o, cache_wrb_req_o;
    logic vc_swap_o, vc_insert_o, vc_wrb_req_o, vc_clean_o;
    logic mem_req_o, mem_wr_o, mem_kill_o;
    logic [1:0] evict_index_o;
    logic [1:0] vc_index_o;
`ifdef WB_DCACHE_PERF_EN
    logic [31:0] hit_cnt_o, miss_cnt_o, vc_hit_cnt_o, wb_cnt_o;
`endif

    wb_dcache_victim_ctrl #(
        .IDX_BITS    (IDX_BITS),
        .VC_ENTRIES  (VC_ENTRIES),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .lsu_req_i          (lsu_req_i),
        .lsu_wr_i           (lsu_wr_i),
        .lsu_kill_i         (lsu_kill_i),
        .dmem_sel_i         (dmem_sel_i),
        .flush_i            (flush_i),
        .lsu_ack_o          (lsu_ack_o),
        .lsu_err_o          (lsu_err_o),
        .lsu_vc_sel_o       (lsu_vc_sel_o),
        .cache_hit_i        (cache_hit_i),
        .cache_valid_i      (cache_valid_i),
        .cache_dirty_i      (cache_dirty_i),
        .cache_wr_o         (cache_wr_o),
        .cache_line_wr_o    (cache_line_wr_o),
        .cache_line_clean_o (cache_line_clean_o),
        .cache_wrb_req_o    (cache_wrb_req_o),
        .evict_index_o      (evict_index_o),
        .vc_hit_i           (vc_hit_i),
        .vc_dirty_i         (vc_dirty_i),
        .vc_swap_o          (vc_swap_o),
        .vc_insert_o        (vc_insert_o),
        .vc_wrb_req_o       (vc_wrb_req_o),
        .vc_clean_o         (vc_clean_o),
        .vc_index_o         (vc_index_o),
        .mem_ack_i          (mem_ack_i),
        .mem_req_o          (mem_req_o),
        .mem_wr_o           (mem_wr_o),
        .mem_kill_o         (mem_kill_o)
`ifdef WB_DCACHE_PERF_EN
        ,
        .hit_cnt_o          (hit_cnt_o),
        .miss_cnt_o         (miss_cnt_o),
        .vc_hit_cnt_o       (vc_hit_cnt_o),
        .wb_cnt_o           (wb_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // wr, hit, vc_hit, valid, vc_dirty, then expected
    // {ack, cache_wr, vc_swap, vc_sel, vc_insert, mem_req, mem_wr, vc_wrb} in PROCESS.
    typedef struct packed {
        logic       wr;
        logic       hit;
        logic       vch;
        logic       valid;
        logic       vdirty;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [9];
    int   n_cmp = 0;
    int   n_err = 0;

    int         acks, wbs, dcl, vcl, ack_at;
    logic [1:0] ev_at, vc_at;
    logic       err_at, prev_req, prev_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [13:0] all_out();
        return {lsu_ack_o, lsu_err_o, lsu_vc_sel_o, cache_wr_o, cache_line_wr_o,
                cache_line_clean_o, cache_wrb_req_o, vc_swap_o, vc_insert_o,
                vc_wrb_req_o, vc_clean_o, mem_req_o, mem_wr_o, mem_kill_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        vecs[0] = '{wr:1'b0, hit:1'b1, vch:1'b0, valid:1'b0, vdirty:1'b0, exp:8'b1000_0000};
        vecs[1] = '{wr:1'b1, hit:1'b1, vch:1'b0, valid:1'b0, vdirty:1'b0, exp:8'b1100_0000};
        vecs[2] = '{wr:1'b0, hit:1'b0, vch:1'b1, valid:1'b1, vdirty:1'b0, exp:8'b0011_0000};
        vecs[3] = '{wr:1'b1, hit:1'b0, vch:1'b1, valid:1'b1, vdirty:1'b1, exp:8'b0010_0000};
        vecs[4] = '{wr:1'b0, hit:1'b0, vch:1'b0, valid:1'b0, vdirty:1'b0, exp:8'b0000_0100};
        vecs[5] = '{wr:1'b1, hit:1'b0, vch:1'b0, valid:1'b1, vdirty:1'b0, exp:8'b0000_1100};
        vecs[6] = '{wr:1'b0, hit:1'b0, vch:1'b0, valid:1'b1, vdirty:1'b1, exp:8'b0000_1111};
        vecs[7] = '{wr:1'b0, hit:1'b0, vch:1'b0, valid:1'b0, vdirty:1'b1, exp:8'b0000_0100};
        vecs[8] = '{wr:1'b1, hit:1'b1, vch:1'b1, valid:1'b1, vdirty:1'b1, exp:8'b1100_0000};

        repeat (3) next_cycle();
        rst = 1'b0;
        settle();
        check("reset_outputs", 32'(all_out()), 32'd0);
        check("reset_pointers", {evict_index_o, vc_index_o}, 32'd0);
        $display("reset done");

        // Table: cycle 0 request, cycle 1 PROCESS outcome, cycle 2 kill back to IDLE.
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            lsu_req_i = 1'b1;
            lsu_wr_i  = vecs[i].wr;
            next_cycle();
            cache_hit_i   = vecs[i].hit;
            vc_hit_i      = vecs[i].vch;
            cache_valid_i = vecs[i].valid;
            vc_dirty_i    = vecs[i].vdirty;
            settle();
            check($sformatf("vec%0d_process", i),
                  {lsu_ack_o, cache_wr_o, vc_swap_o, lsu_vc_sel_o, vc_insert_o,
                   mem_req_o, mem_wr_o, vc_wrb_req_o}, vecs[i].exp);
            next_cycle();
            lsu_req_i = 0; lsu_wr_i = 0; cache_hit_i = 0; vc_hit_i = 0;
            cache_valid_i = 0; vc_dirty_i = 0; lsu_kill_i = 1;
            next_cycle();
            lsu_kill_i = 0;
            $display("vec %0d applied", i);
        end

        // Write victim hit: swap at cycle 1, line write + word write + ack at cycle 2.
        next_cycle();
        lsu_req_i = 1; lsu_wr_i = 1;
        next_cycle();
        vc_hit_i = 1;
        settle();
        check("vchit_swap", {vc_swap_o, lsu_vc_sel_o, lsu_ack_o}, 32'b100);
        next_cycle();
        vc_hit_i = 0;
        settle();
        check("vchit_fill", {cache_line_wr_o, cache_wr_o, lsu_ack_o}, 32'b111);
        next_cycle();
        lsu_req_i = 0; lsu_wr_i = 0;
        settle();
        check("vchit_idle", {lsu_ack_o, cache_line_wr_o}, 32'd0);
        $display("write victim hit sequence done");

        // Miss with valid line and dirty victim entry.
        next_cycle();
        lsu_req_i = 1;
        next_cycle();
        cache_valid_i = 1; vc_dirty_i = 1;
        settle();
        check("vcwb_enter", {vc_insert_o, mem_req_o, mem_wr_o, vc_wrb_req_o}, 32'hf);
        for (int c = 2; c <= 4; c++) begin
            next_cycle();
            mem_ack_i = (c == 4);
            settle();
            check($sformatf("vcwb_c%0d", c), {mem_req_o, mem_wr_o, vc_wrb_req_o, lsu_ack_o}, 32'b1110);
        end
        for (int c = 5; c <= 9; c++) begin
            next_cycle();
            mem_ack_i = (c == 9);
            settle();
            check($sformatf("alloc_c%0d", c), {mem_req_o, mem_wr_o, cache_line_wr_o, lsu_ack_o},
                  {28'd0, 1'b1, 1'b0, (c == 9), 1'b0});
        end
        next_cycle();
        mem_ack_i = 0; cache_hit_i = 1;
        settle();
        check("alloc_hit_ack", {lsu_ack_o, cache_wr_o, mem_req_o}, 32'b100);
        next_cycle();
        lsu_req_i = 0; cache_hit_i = 0; cache_valid_i = 0; vc_dirty_i = 0;
        $display("dirty victim miss sequence done");

        // Timeout: no ack for MEM_TIMEOUT allocate cycles.
        next_cycle();
        lsu_req_i = 1;
        next_cycle();
        for (int c = 2; c <= 9; c++) begin
            next_cycle();
            settle();
            check($sformatf("tmo_c%0d", c), {mem_kill_o, lsu_ack_o, lsu_err_o},
                  (c == 9) ? 32'b111 : 32'b000);
        end
        next_cycle();
        lsu_req_i = 0;
        settle();
        check("tmo_idle", {mem_req_o, lsu_ack_o, mem_kill_o}, 32'd0);
        $display("timeout sequence done");

        // Ack coincident with timeout: ack wins.
        next_cycle();
        lsu_req_i = 1;
        next_cycle();
        for (int c = 2; c <= 8; c++) next_cycle();
        next_cycle();
        mem_ack_i = 1;
        settle();
        check("tmo_ack_race", {cache_line_wr_o, mem_kill_o, lsu_err_o, lsu_ack_o}, 32'b1000);
        next_cycle();
        mem_ack_i = 0; cache_hit_i = 1;
        settle();
        check("tmo_ack_race_hit", {lsu_ack_o, lsu_err_o}, 32'b10);
        next_cycle();
        lsu_req_i = 0; cache_hit_i = 0;
        $display("ack/timeout race sequence done");

        // Kill during ALLOCATE.
        next_cycle();
        lsu_req_i = 1;
        next_cycle();
        next_cycle();
        lsu_kill_i = 1;
        settle();
        check("kill_alloc", {mem_kill_o, mem_req_o, lsu_ack_o, cache_wr_o}, 32'b1000);
        next_cycle();
        lsu_kill_i = 0; lsu_req_i = 0;
        settle();
        check("kill_idle", {mem_req_o, lsu_ack_o, mem_kill_o}, 32'd0);
        $display("kill sequence done");

        // Flush sweep: set 2 dirty, victim entry 1 dirty; memory acks one cycle after a request.
        next_cycle();
        flush_i = 1;
        acks = 0; wbs = 0; dcl = 0; vcl = 0; ack_at = -1;
        ev_at = '0; vc_at = '0; err_at = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            next_cycle();
            if (ack_at >= 0) flush_i = 0;
            mem_ack_i     = prev_req && !prev_ack;
            cache_dirty_i = (evict_index_o == 2'd2) && (dcl == 0);
            vc_dirty_i    = (vc_index_o == 2'd1) && (vcl == 0);
            settle();
            if (mem_ack_i && mem_req_o && mem_wr_o) wbs++;
            if (cache_line_clean_o) dcl++;
            if (vc_clean_o) vcl++;
            if (lsu_ack_o) begin
                acks++;
                if (ack_at < 0) begin
                    ack_at = c;
                    ev_at  = evict_index_o;
                    vc_at  = vc_index_o;
                    err_at = lsu_err_o;
                end
            end
            prev_req = mem_req_o;
            prev_ack = mem_ack_i;
            if (ack_at >= 0 && c >= ack_at + 3) break;
        end
        flush_i = 0; mem_ack_i = 0; cache_dirty_i = 0; vc_dirty_i = 0;
        check("flush_ack_seen", 32'(ack_at >= 0), 32'd1);
        check("flush_ack_count", acks, 32'd1);
        check("flush_writebacks", wbs, 32'd2);
        check("flush_dc_clean", dcl, 32'd1);
        check("flush_vc_clean", vcl, 32'd1);
        check("flush_evict_index", ev_at, 32'd3);
        check("flush_vc_index", vc_at, 32'(VC_ENTRIES - 1));
        check("flush_err", err_at, 32'd0);
        $display("flush sequence done");

        // Reset in the middle of an allocate.
        next_cycle();
        lsu_req_i = 1;
        next_cycle();
        next_cycle();
        settle();
        check("rst_pre_req", mem_req_o, 32'd1);
        next_cycle();
        rst = 1;
        next_cycle();
        rst = 0; lsu_req_i = 0;
        settle();
        check("rst_mid_outputs", 32'(all_out()), 32'd0);
        $display("mid-transaction reset sequence done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
